// File: rtl/radar_statistics_core_if.sv
`default_nettype none
// ============================================================================
// radar_statistics_core_if : radar inputs and measurement results bundle
// Revision 1.0 - initial release
// ============================================================================
interface radar_statistics_core_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  ARP;
   logic                  ACP;
   logic                  TRIG;
   logic                  USEC;
   logic                  CALIBRATED;
   logic [DATA_WIDTH-1:0] ARP_US;
   logic [DATA_WIDTH-1:0] ACP_CNT;
   logic [DATA_WIDTH-1:0] TRIG_US;

   modport master (
      output ARP, ACP, TRIG, USEC,
      input  CALIBRATED, ARP_US, ACP_CNT, TRIG_US
   );

   modport slave (
      input  ARP, ACP, TRIG, USEC,
      output CALIBRATED, ARP_US, ACP_CNT, TRIG_US
   );
endinterface
`default_nettype wire

// File: rtl/radar_statistics_core.sv
`default_nettype none
// ============================================================================
// radar_statistics_core : measures ARP period, ACP count per rotation and
//                         TRIG period in USEC ticks; flags CALIBRATED.
// Revision 1.0 - initial release
// ============================================================================
module radar_statistics_core #(
   parameter int DATA_WIDTH = 32
) (
   input  wire logic              SYS_CLK,
   input  wire logic              SYS_RESETN,
   radar_statistics_core_if.slave bus
);
   localparam int                    NUM_IN   = 4;
   localparam int                    IDX_ARP  = 0;
   localparam int                    IDX_ACP  = 1;
   localparam int                    IDX_TRIG = 2;
   localparam int                    IDX_USEC = 3;
   localparam logic [DATA_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [DATA_WIDTH-1:0] CNT_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [DATA_WIDTH-1:0] sat_inc(
      input logic [DATA_WIDTH-1:0] value,
      input logic                  inc
   );
      return (inc && (value != CNT_MAX)) ? (value + CNT_ONE) : value;
   endfunction

   logic [NUM_IN-1:0] raw_in;
   logic [NUM_IN-1:0] meta_q;
   logic [NUM_IN-1:0] sync_q;
   logic [NUM_IN-1:0] hist_q;
   logic [NUM_IN-1:0] ev_q;

   logic arp_ev;
   logic acp_ev;
   logic trig_ev;
   logic usec_ev;

   logic [DATA_WIDTH-1:0] arp_us_cnt_q,  arp_us_cnt_d;
   logic [DATA_WIDTH-1:0] acp_cnt_q,     acp_cnt_d;
   logic [DATA_WIDTH-1:0] trig_us_cnt_q, trig_us_cnt_d;
   logic [DATA_WIDTH-1:0] arp_us_q,      arp_us_d;
   logic [DATA_WIDTH-1:0] acp_total_q,   acp_total_d;
   logic [DATA_WIDTH-1:0] trig_us_q,     trig_us_d;
   logic                  arp_seen_q,    arp_seen_d;
   logic                  trig_seen_q,   trig_seen_d;
   logic                  arp_valid_q,   arp_valid_d;
   logic                  trig_valid_q,  trig_valid_d;
   logic                  calibrated_q,  calibrated_d;

   assign raw_in = {bus.USEC, bus.TRIG, bus.ACP, bus.ARP};

   // Two synchronizer stages, then a registered rising-edge pulse per input.
   always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
      if (!SYS_RESETN) begin
         meta_q <= '0;
         sync_q <= '0;
         hist_q <= '0;
         ev_q   <= '0;
      end else begin
         meta_q <= raw_in;
         sync_q <= meta_q;
         hist_q <= sync_q;
         ev_q   <= sync_q & ~hist_q;
      end
   end

   assign arp_ev  = ev_q[IDX_ARP];
   assign acp_ev  = ev_q[IDX_ACP];
   assign trig_ev = ev_q[IDX_TRIG];
   assign usec_ev = ev_q[IDX_USEC];

   always_comb begin
      arp_us_cnt_d  = sat_inc(arp_us_cnt_q, usec_ev);
      acp_cnt_d     = sat_inc(acp_cnt_q, acp_ev);
      trig_us_cnt_d = sat_inc(trig_us_cnt_q, usec_ev);
      arp_us_d      = arp_us_q;
      acp_total_d   = acp_total_q;
      trig_us_d     = trig_us_q;
      arp_seen_d    = arp_seen_q;
      trig_seen_d   = trig_seen_q;
      arp_valid_d   = arp_valid_q;
      trig_valid_d  = trig_valid_q;

      // Events coinciding with the closing edge belong to the closing period.
      if (arp_ev) begin
         arp_seen_d   = 1'b1;
         arp_us_cnt_d = '0;
         acp_cnt_d    = '0;
         if (arp_seen_q) begin
            arp_us_d    = sat_inc(arp_us_cnt_q, usec_ev);
            acp_total_d = sat_inc(acp_cnt_q, acp_ev);
            arp_valid_d = 1'b1;
         end
      end

      if (trig_ev) begin
         trig_seen_d   = 1'b1;
         trig_us_cnt_d = '0;
         if (trig_seen_q) begin
            trig_us_d    = sat_inc(trig_us_cnt_q, usec_ev);
            trig_valid_d = 1'b1;
         end
      end

      calibrated_d = calibrated_q | (arp_valid_d & trig_valid_d);
   end

   always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
      if (!SYS_RESETN) begin
         arp_us_cnt_q  <= '0;
         acp_cnt_q     <= '0;
         trig_us_cnt_q <= '0;
         arp_us_q      <= '0;
         acp_total_q   <= '0;
         trig_us_q     <= '0;
         arp_seen_q    <= 1'b0;
         trig_seen_q   <= 1'b0;
         arp_valid_q   <= 1'b0;
         trig_valid_q  <= 1'b0;
         calibrated_q  <= 1'b0;
      end else begin
         arp_us_cnt_q  <= arp_us_cnt_d;
         acp_cnt_q     <= acp_cnt_d;
         trig_us_cnt_q <= trig_us_cnt_d;
         arp_us_q      <= arp_us_d;
         acp_total_q   <= acp_total_d;
         trig_us_q     <= trig_us_d;
         arp_seen_q    <= arp_seen_d;
         trig_seen_q   <= trig_seen_d;
         arp_valid_q   <= arp_valid_d;
         trig_valid_q  <= trig_valid_d;
         calibrated_q  <= calibrated_d;
      end
   end

   assign bus.ARP_US     = arp_us_q;
   assign bus.ACP_CNT    = acp_total_q;
   assign bus.TRIG_US    = trig_us_q;
   assign bus.CALIBRATED = calibrated_q;
endmodule
`default_nettype wire

// File: tb/tb_radar_statistics_core.sv
`default_nettype none
// ============================================================================
// tb_radar_statistics_core : drives 32-bit and 8-bit builds with a shared
//                            stimulus; checks against an edge-timestamp model.
// Revision 1.0 - initial release
// ============================================================================
module tb_radar_statistics_core;
   localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
   localparam longint MAX8  = 255;
   localparam int     LAT   = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   radar_statistics_core_if #(.DATA_WIDTH(32)) if32 ();
   radar_statistics_core_if #(.DATA_WIDTH(8))  if8  ();

   radar_statistics_core #(.DATA_WIDTH(32)) u_dut32 (
      .SYS_CLK    (clk),
      .SYS_RESETN (rst_n),
      .bus        (if32.slave)
   );

   radar_statistics_core #(.DATA_WIDTH(8)) u_dut8 (
      .SYS_CLK    (clk),
      .SYS_RESETN (rst_n),
      .bus        (if8.slave)
   );

   typedef struct {
      int     ap, acp_p, tp, up, acph, ncyc;
      longint e_arp, e_acp, e_trig;
   } vec_t;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Model: timestamps of rising edges, period closed by counting stamps in (last, now].
   longint usec_q[$];
   longint acp_q[$];
   longint last_arp, last_trig;
   bit     arp_lat, trig_lat, cal_m;
   longint m_arp_us, m_acp, m_trig_us;
   logic   p_arp, p_acp, p_trig, p_usec;
   longint h_arp[8], h_acp[8], h_trig[8];
   bit     h_cal[8];
   int     n_arp, n_trig;
   int     t_cal_due, t_cal_seen;

   function automatic longint sat(input longint v, input longint mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic logic sq(input int c, input int p, input int ph);
      return ((c + ph) % p) < (p / 2);
   endfunction

   function automatic longint count_in(input bit use_acp, input longint lo, input longint hi);
      longint n = 0;
      if (use_acp) begin
         foreach (acp_q[k]) if (acp_q[k] > lo && acp_q[k] <= hi) n++;
      end else begin
         foreach (usec_q[k]) if (usec_q[k] > lo && usec_q[k] <= hi) n++;
      end
      return n;
   endfunction

   task automatic model_clear();
      usec_q.delete();
      acp_q.delete();
      last_arp  = -1;
      last_trig = -1;
      arp_lat   = 1'b0;
      trig_lat  = 1'b0;
      cal_m     = 1'b0;
      m_arp_us  = 0;
      m_acp     = 0;
      m_trig_us = 0;
      {p_arp, p_acp, p_trig, p_usec} = 4'b0000;
      for (int k = 0; k < 8; k++) begin
         h_arp[k] = 0; h_acp[k] = 0; h_trig[k] = 0; h_cal[k] = 1'b0;
      end
      n_arp      = 0;
      n_trig     = 0;
      t_cal_due  = -1;
      t_cal_seen = -1;
   endtask

   task automatic model_update(input logic a, input logic ac, input logic t, input logic u);
      longint now, lo_a, lo_t, lo_u;
      now = longint'(cyc);
      if (u && !p_usec) usec_q.push_back(now);
      if (ac && !p_acp) acp_q.push_back(now);
      if (a && !p_arp) begin
         n_arp++;
         if (last_arp >= 0) begin
            m_arp_us = count_in(1'b0, last_arp, now);
            m_acp    = count_in(1'b1, last_arp, now);
            arp_lat  = 1'b1;
         end
         last_arp = now;
      end
      if (t && !p_trig) begin
         n_trig++;
         if (last_trig >= 0) begin
            m_trig_us = count_in(1'b0, last_trig, now);
            trig_lat  = 1'b1;
         end
         last_trig = now;
      end
      if (arp_lat && trig_lat) cal_m = 1'b1;
      if (t_cal_due < 0 && n_arp >= 2 && n_trig >= 2) t_cal_due = cyc;
      {p_arp, p_acp, p_trig, p_usec} = {a, ac, t, u};
      lo_a = (last_arp  >= 0) ? last_arp  : now;
      lo_t = (last_trig >= 0) ? last_trig : now;
      lo_u = (lo_a < lo_t) ? lo_a : lo_t;
      while (usec_q.size() > 0 && usec_q[0] <= lo_u) void'(usec_q.pop_front());
      while (acp_q.size() > 0 && acp_q[0] <= lo_a) void'(acp_q.pop_front());
      h_arp[cyc % 8]  = m_arp_us;
      h_acp[cyc % 8]  = m_acp;
      h_trig[cyc % 8] = m_trig_us;
      h_cal[cyc % 8]  = cal_m;
   endtask

   task automatic check_val(input string what, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", what, act, exp);
      end
   endtask

   task automatic check_state(input string who, input logic [63:0] a_us, input logic [63:0] ac,
                              input logic [63:0] t_us, input logic cal, input longint mx);
      int         k;
      logic [63:0] ea, ec, et;
      k  = (cyc + 8 - LAT) % 8;
      ea = sat(h_arp[k], mx);
      ec = sat(h_acp[k], mx);
      et = sat(h_trig[k], mx);
      checks++;
      if (a_us !== ea || ac !== ec || t_us !== et || cal !== h_cal[k]) begin
         errors++;
         $display("FAIL %s cycle %0d: ARP_US=%0d ACP_CNT=%0d TRIG_US=%0d CAL=%b, expected %0d %0d %0d %b",
                  who, cyc, a_us, ac, t_us, cal, ea, ec, et, h_cal[k]);
      end
   endtask

   task automatic drive(input logic a, input logic ac, input logic t, input logic u);
      if32.ARP = a; if32.ACP = ac; if32.TRIG = t; if32.USEC = u;
      if8.ARP  = a; if8.ACP  = ac; if8.TRIG  = t; if8.USEC  = u;
   endtask

   task automatic step(input logic a, input logic ac, input logic t, input logic u);
      @(negedge clk);
      check_state("dut32", 64'(if32.ARP_US), 64'(if32.ACP_CNT), 64'(if32.TRIG_US), if32.CALIBRATED, MAX32);
      check_state("dut8",  64'(if8.ARP_US),  64'(if8.ACP_CNT),  64'(if8.TRIG_US),  if8.CALIBRATED,  MAX8);
      if (t_cal_seen < 0 && if32.CALIBRATED === 1'b1) t_cal_seen = cyc;
      drive(a, ac, t, u);
      model_update(a, ac, t, u);
      cyc++;
   endtask

   task automatic run_scn(input int ap, input int acp_p, input int tp, input int up,
                          input int aph, input int acph, input int tph, input int uph,
                          input int a_off, input int ncyc);
      repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < ncyc; c++)
         step((c >= a_off) && sq(c, ap, aph), sq(c, acp_p, acph), sq(c, tp, tph), sq(c, up, uph));
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, " dut32 ARP_US"},  64'(if32.ARP_US),     64'd0);
      check_val({tag, " dut32 ACP_CNT"}, 64'(if32.ACP_CNT),    64'd0);
      check_val({tag, " dut32 TRIG_US"}, 64'(if32.TRIG_US),    64'd0);
      check_val({tag, " dut32 CAL"},     64'(if32.CALIBRATED), 64'd0);
      check_val({tag, " dut8 ARP_US"},   64'(if8.ARP_US),      64'd0);
      check_val({tag, " dut8 CAL"},      64'(if8.CALIBRATED),  64'd0);
   endtask

   task automatic check_steady(input string tag, input longint ea, input longint ec, input longint et);
      check_val({tag, " ARP_US"},     64'(if32.ARP_US),     64'(ea));
      check_val({tag, " ACP_CNT"},    64'(if32.ACP_CNT),    64'(ec));
      check_val({tag, " TRIG_US"},    64'(if32.TRIG_US),    64'(et));
      check_val({tag, " CAL"},        64'(if32.CALIBRATED), 64'd1);
      check_val({tag, " dut8 ARP_US"}, 64'(if8.ARP_US),     64'(ea));
   endtask

   task automatic check_cal_latency(input string tag);
      int d;
      d = t_cal_seen - t_cal_due;
      checks++;
      if (t_cal_due < 0 || t_cal_seen < 0 || d < 1 || d > LAT) begin
         errors++;
         $display("FAIL %s cal latency: got %0d cycles (due %0d seen %0d), expected 1..%0d",
                  tag, d, t_cal_due, t_cal_seen, LAT);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check_zero("reset_async");
      model_clear();
      repeat (3) @(negedge clk);
      check_zero("reset_hold");
      rst_n = 1'b1;
   endtask

   initial begin
      vec_t tbl[5];
      int   up, ap, acp_p, tp;

      // USEC tick = 8 clocks here, so 125 ticks of ARP = 1000 clocks.
      tbl[0] = '{1000, 200, 40, 8,   0, 5500, 125,  5, 5};
      tbl[1] = '{2000, 200, 40, 8,   0, 6500, 250, 10, 5};
      tbl[2] = '{1000, 250, 50, 10,  0, 4500, 100,  4, 5};
      tbl[3] = '{1000, 500, 40, 8,   0, 2500, 125,  2, 5};
      tbl[4] = '{1000, 500, 40, 8, 499, 2500, 125,  2, 5};

      model_clear();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      for (int v = 0; v < 5; v++) begin
         run_scn(tbl[v].ap, tbl[v].acp_p, tbl[v].tp, tbl[v].up,
                 0, tbl[v].acph, 0, 0, 0, tbl[v].ncyc);
         check_steady($sformatf("vec%0d", v), tbl[v].e_arp, tbl[v].e_acp, tbl[v].e_trig);
         if (v == 0) check_cal_latency("startup");
      end

      // ARP stalled for 300 ticks: 8-bit build must latch its saturated count.
      run_scn(1000, 200, 40, 8, 0, 0, 0, 0, 2400, 2450);
      check_val("stall dut8 ARP_US", 64'(if8.ARP_US), 64'd255);
      checks++;
      if ($isunknown(if32.ARP_US) || if32.ARP_US <= 32'd255) begin
         errors++;
         $display("FAIL stall dut32 ARP_US: got %0d, expected above 255", if32.ARP_US);
      end

      run_scn(1000, 200, 40, 8, 0, 0, 0, 0, 0, 2400);
      do_reset();
      run_scn(1000, 200, 40, 8, 0, 0, 0, 0, 0, 4500);
      check_steady("after_reset", 125, 5, 5);
      check_cal_latency("after_reset");

      for (int n = 0; n < 6; n++) begin
         up    = int'($urandom_range(4, 12));
         ap    = up * int'($urandom_range(10, 60)) + int'($urandom_range(0, up - 1));
         acp_p = int'($urandom_range(4, 150));
         tp    = int'($urandom_range(4, 100));
         run_scn(ap, acp_p, tp, up,
                 int'($urandom_range(0, ap - 1)), int'($urandom_range(0, acp_p - 1)),
                 int'($urandom_range(0, tp - 1)), int'($urandom_range(0, up - 1)),
                 0, 3 * ap + int'($urandom_range(50, 300)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
